// File: rtl/ts_os_decoder.sv
// ts_os_decoder
// Per-lane Gen1/Gen2 TS1/TS2 ordered-set framer, checker and field extractor
// for the RX LTSSM path. Each lane also counts consecutive identical TS.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   data, datak       one decoded symbol and K flag per lane (lane n = data[8n+:8])
//   valid             symbols valid this cycle (all lanes)
//   lane_en           active-lane mask used for all_consec_ok
//   ts_valid, os_err  one-cycle pulses: TS accepted / malformed or interrupted set
//   ts_is_ts2         type of last accepted TS
//   link_num .. train_ctl, link_pad, lane_pad   fields of last accepted TS
//   consec_cnt, consec_ok, all_consec_ok        consecutive identical TS tracking
//
// state | meaning
// HUNT  | waiting for COM
// BODY  | inside a TS, idx = index of the symbol expected next (1..15)
// SKIP  | inside a SKP ordered set, waiting for COM or end of SKPs
module ts_os_decoder #(
  parameter int LANES  = 16,
  parameter int CONSEC = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*LANES-1:0]   data,
  input  logic [LANES-1:0]     datak,
  input  logic                 valid,
  input  logic [LANES-1:0]     lane_en,
  output logic [LANES-1:0]     ts_valid,
  output logic [LANES-1:0]     ts_is_ts2,
  output logic [8*LANES-1:0]   link_num,
  output logic [8*LANES-1:0]   lane_num,
  output logic [8*LANES-1:0]   n_fts,
  output logic [8*LANES-1:0]   rate_id,
  output logic [8*LANES-1:0]   train_ctl,
  output logic [LANES-1:0]     link_pad,
  output logic [LANES-1:0]     lane_pad,
  output logic [LANES-1:0]     os_err,
  output logic [8*LANES-1:0]   consec_cnt,
  output logic [LANES-1:0]     consec_ok,
  output logic                 all_consec_ok
);

  localparam logic [7:0] CONSEC_MAX = 8'(CONSEC);
  localparam logic [7:0] SYM_COM    = 8'hBC;
  localparam logic [7:0] SYM_SKP    = 8'h1C;
  localparam logic [7:0] SYM_PAD    = 8'hF7;
  localparam logic [7:0] ID_TS1     = 8'h4A;
  localparam logic [7:0] ID_TS2     = 8'h45;

  typedef enum logic [1:0] {HUNT, BODY, SKIP} state_t;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] sym;
    logic       k, is_com, is_skp, is_pad;
    state_t     state;
    logic [3:0] idx;
    logic       ts2_sh, link_pad_sh, lane_pad_sh;
    logic [7:0] link_sh, lane_sh, nfts_sh, rate_sh, ctl_sh;
    logic       ts_valid_q, os_err_q, ts2_q, link_pad_q, lane_pad_q;
    logic [7:0] link_q, lane_q, nfts_q, rate_q, ctl_q, cnt_q;
    logic       body_err, same_prev;
    logic [7:0] exp_id, cnt_next;

    assign sym    = data[8*g +: 8];
    assign k      = datak[g];
    assign is_com = k && (sym == SYM_COM);
    assign is_skp = k && (sym == SYM_SKP);
    assign is_pad = k && (sym == SYM_PAD);
    assign exp_id = ts2_sh ? ID_TS2 : ID_TS1;

    always_comb begin
      body_err = 1'b0;
      case (idx)
        4'd1:                body_err = k && !is_pad && !is_skp;
        4'd2:                body_err = k && !is_pad;
        4'd3, 4'd4, 4'd5:    body_err = k;
        4'd6:                body_err = k || ((sym != ID_TS1) && (sym != ID_TS2));
        default:             body_err = k || (sym != exp_id);
      endcase
    end

    // The candidate TS matches the last committed one only if a run is already
    // in progress; a zero count (after reset or an error) always restarts at 1.
    assign same_prev = (cnt_q != 8'd0) &&
                       (ts2_sh == ts2_q) &&
                       (link_sh == link_q) && (link_pad_sh == link_pad_q) &&
                       (lane_sh == lane_q) && (lane_pad_sh == lane_pad_q) &&
                       (nfts_sh == nfts_q) && (rate_sh == rate_q) && (ctl_sh == ctl_q);
    assign cnt_next  = !same_prev ? 8'd1 :
                       (cnt_q >= CONSEC_MAX) ? CONSEC_MAX : cnt_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state       <= HUNT;
        idx         <= 4'd0;
        ts2_sh      <= 1'b0;
        link_pad_sh <= 1'b0;
        lane_pad_sh <= 1'b0;
        link_sh     <= 8'd0;
        lane_sh     <= 8'd0;
        nfts_sh     <= 8'd0;
        rate_sh     <= 8'd0;
        ctl_sh      <= 8'd0;
        ts_valid_q  <= 1'b0;
        os_err_q    <= 1'b0;
        ts2_q       <= 1'b0;
        link_pad_q  <= 1'b0;
        lane_pad_q  <= 1'b0;
        link_q      <= 8'd0;
        lane_q      <= 8'd0;
        nfts_q      <= 8'd0;
        rate_q      <= 8'd0;
        ctl_q       <= 8'd0;
        cnt_q       <= 8'd0;
      end else begin
        ts_valid_q <= 1'b0;
        os_err_q   <= 1'b0;
        if (valid) begin
          case (state)
            HUNT: begin
              if (is_com) begin
                state <= BODY;
                idx   <= 4'd1;
              end
            end
            SKIP: begin
              if (is_com) begin
                state <= BODY;
                idx   <= 4'd1;
              end else if (!is_skp) begin
                state <= HUNT;
              end
            end
            BODY: begin
              if ((idx == 4'd1) && is_skp) begin
                state <= SKIP;
              end else if (body_err) begin
                os_err_q <= 1'b1;
                cnt_q    <= 8'd0;
                // A COM in the middle of a set is taken as the start of the next one.
                if (is_com) begin
                  state <= BODY;
                  idx   <= 4'd1;
                end else begin
                  state <= HUNT;
                end
              end else begin
                case (idx)
                  4'd1: begin link_sh <= sym; link_pad_sh <= k; end
                  4'd2: begin lane_sh <= sym; lane_pad_sh <= k; end
                  4'd3: nfts_sh <= sym;
                  4'd4: rate_sh <= sym;
                  4'd5: ctl_sh  <= sym;
                  4'd6: ts2_sh  <= (sym == ID_TS2);
                  default: ;
                endcase
                if (idx == 4'd15) begin
                  ts_valid_q <= 1'b1;
                  ts2_q      <= ts2_sh;
                  link_q     <= link_sh;
                  link_pad_q <= link_pad_sh;
                  lane_q     <= lane_sh;
                  lane_pad_q <= lane_pad_sh;
                  nfts_q     <= nfts_sh;
                  rate_q     <= rate_sh;
                  ctl_q      <= ctl_sh;
                  cnt_q      <= cnt_next;
                  state      <= HUNT;
                end else begin
                  idx <= idx + 4'd1;
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end
    end

    assign ts_valid[g]         = ts_valid_q;
    assign os_err[g]           = os_err_q;
    assign ts_is_ts2[g]        = ts2_q;
    assign link_pad[g]         = link_pad_q;
    assign lane_pad[g]         = lane_pad_q;
    assign link_num[8*g +: 8]  = link_q;
    assign lane_num[8*g +: 8]  = lane_q;
    assign n_fts[8*g +: 8]     = nfts_q;
    assign rate_id[8*g +: 8]   = rate_q;
    assign train_ctl[8*g +: 8] = ctl_q;
    assign consec_cnt[8*g +: 8] = cnt_q;
    assign consec_ok[g]        = (cnt_q >= CONSEC_MAX);
  end

  // Lanes outside lane_en are forced true; an empty mask never reports ready.
  assign all_consec_ok = (lane_en != '0) && (&(consec_ok | ~lane_en));

endmodule
